// File: rtl/pq_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// pq_cmd_arbiter
//
// Round-robin command arbiter and sequencer in front of the priority-queue
// cell array. One push/pop/drop is in flight at a time: it is granted, issued
// to the array as a single-cycle pulse, completed by the array's strobe, and
// answered with a one-cycle response to the requester that owns it.
// Occupancy is tracked locally so that overflow and underflow are rejected
// without touching the array.
//
// Optional feature (compile-time macro): PQ_ARB_TIMEOUT_EN
//   When defined, WAIT gives up after TO_CYC cycles without the matching
//   strobe, answers with an error and raises the sticky timeout_o flag.
//   When undefined, WAIT holds indefinitely and timeout_o is tied low.
//
// Ports
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   req_valid_i[NR]         per-requester request valid
//   req_op_i[2*NR]          per-requester op: 00 push, 01 pop, 10 drop, 11 illegal
//   req_id_i[IW*NR]         per-requester ID (push/drop)
//   req_prio_i[PW*NR]       per-requester priority (push)
//   req_ready_o[NR]         grant, one-hot or zero
//   rsp_valid_o[NR]         one-cycle response strobe to the owning requester
//   rsp_err_o               response error flag
//   rsp_id_o, rsp_prio_o    popped entry (0 for push/drop)
//   pq_push_o/pop_o/drop_o  one-cycle command pulses to the array
//   pq_id_o, pq_prio_o      command ID (push/drop) and priority (push)
//   pq_*_vld_i              array completion strobes
//   pq_drop_hit_i           drop completed and the ID was found
//   pq_id_i, pq_prio_i      head entry, valid with pq_pop_vld_i
//   count_o                 current occupancy
//   timeout_o               sticky completion-timeout flag
//   dbg_state               current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Handshake: a request transfers in the cycle where req_valid_i[r] and
// req_ready_o[r] are both high. Ready is only ever raised for a requester
// whose valid is already high, and only in IDLE outside reset; requesters
// keep their request fields stable until that cycle and may withdraw valid
// before it.
// ---------------------------------------------------------------------------
module pq_cmd_arbiter #(
    parameter int NR     = 4,
    parameter int IW     = 4,
    parameter int PW     = 8,
    parameter int DEPTH  = 8,
    parameter int TO_CYC = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR-1:0]              req_valid_i,
    input  logic [2*NR-1:0]            req_op_i,
    input  logic [IW*NR-1:0]           req_id_i,
    input  logic [PW*NR-1:0]           req_prio_i,
    output logic [NR-1:0]              req_ready_o,
    output logic [NR-1:0]              rsp_valid_o,
    output logic                       rsp_err_o,
    output logic [IW-1:0]              rsp_id_o,
    output logic [PW-1:0]              rsp_prio_o,
    output logic                       pq_push_o,
    output logic                       pq_pop_o,
    output logic                       pq_drop_o,
    output logic [IW-1:0]              pq_id_o,
    output logic [PW-1:0]              pq_prio_o,
    input  logic                       pq_push_vld_i,
    input  logic                       pq_pop_vld_i,
    input  logic                       pq_drop_vld_i,
    input  logic                       pq_drop_hit_i,
    input  logic [IW-1:0]              pq_id_i,
    input  logic [PW-1:0]              pq_prio_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       timeout_o,
    output logic [1:0]                 dbg_state
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PTRW = (NR > 1) ? $clog2(NR) : 1;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_DROP = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [PTRW-1:0] rr_ptr;
    logic [CW-1:0]   count;
    logic [1:0]      lat_op;
    logic [PTRW-1:0] lat_w;

    // Per-requester views of the packed request buses.
    logic [1:0]      op_arr   [NR];
    logic [IW-1:0]   id_arr   [NR];
    logic [PW-1:0]   prio_arr [NR];

    logic            win_found;
    logic [PTRW-1:0] win_idx;
    logic [PTRW-1:0] cand;
    logic            hs;
    logic [1:0]      sel_op;
    logic [IW-1:0]   sel_id;
    logic [PW-1:0]   sel_prio;
    logic            req_err;
    logic            strobe_match;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            op_arr[i]   = req_op_i[i*2 +: 2];
            id_arr[i]   = req_id_i[i*IW +: IW];
            prio_arr[i] = req_prio_i[i*PW +: PW];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NR; i++) begin
            cand = PTRW'((int'(rr_ptr) + i) % NR);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign hs          = (state == IDLE) && !rst_i && win_found;
    assign req_ready_o = hs ? (NR'(1) << win_idx) : '0;

    assign sel_op   = op_arr[win_idx];
    assign sel_id   = id_arr[win_idx];
    assign sel_prio = prio_arr[win_idx];

    // Requests rejected without reaching the array.
    assign req_err = (sel_op == 2'b11) ||
                     ((sel_op == OP_PUSH) && ((count == CW'(DEPTH)) || (sel_id == '0))) ||
                     ((sel_op == OP_POP) && (count == '0));

    // Only the strobe belonging to the issued op completes it.
    assign strobe_match = ((lat_op == OP_PUSH) && pq_push_vld_i) ||
                          ((lat_op == OP_POP)  && pq_pop_vld_i)  ||
                          ((lat_op == OP_DROP) && pq_drop_vld_i);

`ifdef PQ_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt;
    logic          to_flag;
    assign timeout_o = to_flag;
`else
    // TO_CYC only matters when the timeout is built in.
    logic unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            count       <= '0;
            lat_op      <= '0;
            lat_w       <= '0;
            pq_push_o   <= 1'b0;
            pq_pop_o    <= 1'b0;
            pq_drop_o   <= 1'b0;
            pq_id_o     <= '0;
            pq_prio_o   <= '0;
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_id_o    <= '0;
            rsp_prio_o  <= '0;
`ifdef PQ_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            to_flag     <= 1'b0;
`endif
        end else begin
            // Pulse outputs fall back to zero unless set below.
            pq_push_o   <= 1'b0;
            pq_pop_o    <= 1'b0;
            pq_drop_o   <= 1'b0;
            pq_id_o     <= '0;
            pq_prio_o   <= '0;
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_id_o    <= '0;
            rsp_prio_o  <= '0;

            case (state)
                IDLE: begin
                    if (hs) begin
                        lat_op <= sel_op;
                        lat_w  <= win_idx;
                        rr_ptr <= (win_idx == PTRW'(NR - 1)) ? '0 : win_idx + 1'b1;
                        if (req_err) begin
                            rsp_valid_o <= NR'(1) << win_idx;
                            rsp_err_o   <= 1'b1;
                            state       <= RESP;
                        end else begin
                            // Registered here so the pulse is visible during ISSUE.
                            pq_push_o <= (sel_op == OP_PUSH);
                            pq_pop_o  <= (sel_op == OP_POP);
                            pq_drop_o <= (sel_op == OP_DROP);
                            pq_id_o   <= (sel_op == OP_POP) ? '0 : sel_id;
                            pq_prio_o <= (sel_op == OP_PUSH) ? sel_prio : '0;
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
`ifdef PQ_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= WAIT;
                end

                WAIT: begin
                    if (strobe_match) begin
                        rsp_valid_o <= NR'(1) << lat_w;
                        state       <= RESP;
                        case (lat_op)
                            OP_PUSH: begin
                                if (count != CW'(DEPTH)) count <= count + 1'b1;
                            end
                            OP_POP: begin
                                rsp_id_o   <= pq_id_i;
                                rsp_prio_o <= pq_prio_i;
                                if (count != '0) count <= count - 1'b1;
                            end
                            default: begin
                                rsp_err_o <= ~pq_drop_hit_i;
                                if (pq_drop_hit_i && (count != '0)) count <= count - 1'b1;
                            end
                        endcase
`ifdef PQ_ARB_TIMEOUT_EN
                    end else if (to_cnt == TW'(TO_CYC - 1)) begin
                        // TO_CYC cycles spent in WAIT: abandon, count untouched.
                        rsp_valid_o <= NR'(1) << lat_w;
                        rsp_err_o   <= 1'b1;
                        to_flag     <= 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign count_o   = count;
    assign dbg_state = state;

endmodule

// File: tb/tb_pq_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pq_cmd_arbiter
//
// Directed bench for pq_cmd_arbiter. Drivers push the expected command and
// response into queues; a response monitor and an array model (which also
// checks issued commands) pop and compare as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_pq_cmd_arbiter;

    localparam int NR     = 4;
    localparam int IW     = 4;
    localparam int PW     = 8;
    localparam int DEPTH  = 8;
    localparam int TO_CYC = 16;
    localparam int CW     = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_DROP = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [NR-1:0]    req_valid = '0;
    logic [2*NR-1:0]  req_op    = '0;
    logic [IW*NR-1:0] req_id    = '0;
    logic [PW*NR-1:0] req_prio  = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic             rsp_err;
    logic [IW-1:0]    rsp_id;
    logic [PW-1:0]    rsp_prio;
    logic             pq_push, pq_pop, pq_drop;
    logic [IW-1:0]    pq_id;
    logic [PW-1:0]    pq_prio;
    logic             pq_push_vld = 1'b0;
    logic             pq_pop_vld  = 1'b0;
    logic             pq_drop_vld = 1'b0;
    logic             pq_drop_hit = 1'b0;
    logic [IW-1:0]    pq_id_in    = '0;
    logic [PW-1:0]    pq_prio_in  = '0;
    logic [CW-1:0]    count;
    logic             timeout;
    logic [1:0]       dbg_state;

    pq_cmd_arbiter #(
        .NR(NR), .IW(IW), .PW(PW), .DEPTH(DEPTH), .TO_CYC(TO_CYC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_op_i      (req_op),
        .req_id_i      (req_id),
        .req_prio_i    (req_prio),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_err_o     (rsp_err),
        .rsp_id_o      (rsp_id),
        .rsp_prio_o    (rsp_prio),
        .pq_push_o     (pq_push),
        .pq_pop_o      (pq_pop),
        .pq_drop_o     (pq_drop),
        .pq_id_o       (pq_id),
        .pq_prio_o     (pq_prio),
        .pq_push_vld_i (pq_push_vld),
        .pq_pop_vld_i  (pq_pop_vld),
        .pq_drop_vld_i (pq_drop_vld),
        .pq_drop_hit_i (pq_drop_hit),
        .pq_id_i       (pq_id_in),
        .pq_prio_i     (pq_prio_in),
        .count_o       (count),
        .timeout_o     (timeout),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [NR+IW+PW:0] exp_rsp_q[$];   // {valid, err, id, prio}
    logic [2+IW+PW:0]  exp_cmd_q[$];   // {push, pop, drop, id, prio}

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    int cmd_cnt = 0;
    int cmd_cyc = 0;

    // array model configuration
    int          push_lat = 1;
    int          pop_lat  = 2;
    int          drop_lat = 1;
    bit          withhold = 1'b0;
    bit          stray    = 1'b0;
    bit          hit_cfg  = 1'b1;
    logic [IW-1:0] pop_id   = '0;
    logic [PW-1:0] pop_prio = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Response monitor.
    logic [NR+IW+PW:0] rsp_act, rsp_exp;
    always @(negedge clk) begin
        if (!rst && (rsp_valid != '0)) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_act = {rsp_valid, rsp_err, rsp_id, rsp_prio};
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected", int'(rsp_act), 0);
            end else begin
                rsp_exp = exp_rsp_q.pop_front();
                check("rsp_fields", int'(rsp_act), int'(rsp_exp));
            end
        end
    end

    // Array model: checks each command pulse and answers it.
    logic [2+IW+PW:0] cmd_act, cmd_exp;
    logic c_push, c_pop;
    always @(negedge clk) begin
        if (!rst && (pq_push || pq_pop || pq_drop)) begin
            cmd_cnt++;
            cmd_cyc = cyc;
            cmd_act = {pq_push, pq_pop, pq_drop, pq_id, pq_prio};
            c_push  = pq_push;
            c_pop   = pq_pop;
            if (exp_cmd_q.size() == 0) begin
                check("cmd_unexpected", int'(cmd_act), 0);
            end else begin
                cmd_exp = exp_cmd_q.pop_front();
                check("cmd_fields", int'(cmd_act), int'(cmd_exp));
            end
            if (!withhold) begin
                if (c_push) begin
                    if (stray) begin
                        @(posedge clk); #1;
                        pq_pop_vld = 1'b1; pq_id_in = 4'hf; pq_prio_in = 8'hff;
                        @(posedge clk); #1;
                        pq_pop_vld = 1'b0; pq_id_in = '0; pq_prio_in = '0;
                        repeat (push_lat - 2) @(posedge clk);
                        #1;
                    end else begin
                        repeat (push_lat) @(posedge clk);
                        #1;
                    end
                    pq_push_vld = 1'b1;
                    @(posedge clk); #1;
                    pq_push_vld = 1'b0;
                end else if (c_pop) begin
                    repeat (pop_lat) @(posedge clk);
                    #1;
                    pq_pop_vld = 1'b1; pq_id_in = pop_id; pq_prio_in = pop_prio;
                    @(posedge clk); #1;
                    pq_pop_vld = 1'b0; pq_id_in = '0; pq_prio_in = '0;
                end else begin
                    repeat (drop_lat) @(posedge clk);
                    #1;
                    pq_drop_vld = 1'b1; pq_drop_hit = hit_cfg;
                    @(posedge clk); #1;
                    pq_drop_vld = 1'b0; pq_drop_hit = 1'b0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One request from requester r. Expected latency is counted from the
    // accept cycle to the response cycle.
    task automatic do_req(input int r, input logic [1:0] op, input logic [IW-1:0] id,
                          input logic [PW-1:0] prio, input bit exp_cmd, input bit exp_rsp,
                          input bit e_err, input logic [IW-1:0] e_id, input logic [PW-1:0] e_prio,
                          input int e_lat, input string name);
        int n, acc, base_rsp, base_cmd;
        logic [NR-1:0] ev;
        ev       = NR'(1) << r;
        base_rsp = rsp_cnt;
        base_cmd = cmd_cnt;
        if (exp_cmd)
            exp_cmd_q.push_back({op == OP_PUSH, op == OP_POP, op == OP_DROP,
                                 (op == OP_POP) ? IW'(0) : id,
                                 (op == OP_PUSH) ? prio : PW'(0)});
        if (exp_rsp)
            exp_rsp_q.push_back({ev, e_err, e_id, e_prio});
        req_valid[r]          = 1'b1;
        req_op[2*r +: 2]      = op;
        req_id[IW*r +: IW]    = id;
        req_prio[PW*r +: PW]  = prio;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!req_ready[r] && n < 20);
        check({name, "_grant"}, int'(req_ready), int'(ev));
        acc = cyc;
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        if (exp_cmd) begin
            n = 0;
            while (cmd_cnt == base_cmd && n < 10) begin
                @(negedge clk); #1; n++;
            end
            check({name, "_cmd_lat"}, cmd_cyc - acc, 1);
        end
        if (exp_rsp) begin
            n = 0;
            while (rsp_cnt == base_rsp && n < 60) begin
                @(negedge clk); #1; n++;
            end
            check({name, "_rsp_lat"}, rsp_cyc - acc, e_lat);
        end
        check({name, "_cmd_issued"}, cmd_cnt - base_cmd, int'(exp_cmd));
        @(posedge clk); #1;
    endtask

    // All requesters push at once; grants must come out 0,1,2,3.
    task automatic do_batch();
        int k, n, base;
        logic [NR-1:0] g, ev;
        base = rsp_cnt;
        for (int i = 0; i < NR; i++) begin
            exp_cmd_q.push_back({3'b100, IW'(i + 1), PW'(16 + i)});
            exp_rsp_q.push_back({NR'(1) << i, 1'b0, IW'(0), PW'(0)});
            req_valid[i]         = 1'b1;
            req_op[2*i +: 2]     = OP_PUSH;
            req_id[IW*i +: IW]   = IW'(i + 1);
            req_prio[PW*i +: PW] = PW'(16 + i);
        end
        k = 0;
        n = 0;
        while ((k < NR || (rsp_cnt - base) < NR) && n < 200) begin
            @(negedge clk); #1; n++;
            g = req_ready & req_valid;
            if (g != '0) begin
                ev = NR'(1) << k;
                check("batch_grant", int'(g), int'(ev));
                k++;
                @(posedge clk); #1;
                req_valid = req_valid & ~g;
            end
        end
        check("batch_rsp_count", rsp_cnt - base, NR);
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    int base;
    initial begin
        // Valid held during reset must not be granted.
        req_valid[0]    = 1'b1;
        req_op[1:0]     = OP_PUSH;
        req_id[IW-1:0]  = 4'd1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_ready", int'(req_ready), 0);
        check("reset_count", int'(count), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_rsp", int'(rsp_valid), 0);
        check("reset_pulses", int'({pq_push, pq_pop, pq_drop}), 0);
        check("reset_state", int'(dbg_state), 0);
        req_valid = '0;
        @(posedge clk); #1 rst = 1'b0;

        // Pop on empty: immediate error, array untouched.
        do_req(1, OP_POP, 4'd0, 8'd0, 0, 1, 1, 4'd0, 8'd0, 1, "pop_empty");
        // First push: pulse at accept+1, response at accept+3.
        do_req(0, OP_PUSH, 4'd3, 8'd5, 1, 1, 0, 4'd0, 8'd0, 3, "push_first");
        check("count_after_first", int'(count), 1);

        reset_dut();
        check("count_after_reset", int'(count), 0);

        do_batch();
        check("count_after_batch", int'(count), 4);
        do_req(0, OP_PUSH, 4'd5, 8'h15, 1, 1, 0, 4'd0, 8'd0, 3, "push_5");
        check("count_5", int'(count), 5);
        do_req(1, OP_PUSH, 4'd6, 8'h20, 1, 1, 0, 4'd0, 8'd0, 3, "push_6");
        do_req(1, OP_PUSH, 4'd7, 8'h21, 1, 1, 0, 4'd0, 8'd0, 3, "push_7");
        do_req(1, OP_PUSH, 4'd8, 8'h22, 1, 1, 0, 4'd0, 8'd0, 3, "push_8");
        check("count_full", int'(count), 8);
        do_req(2, OP_PUSH, 4'd9, 8'h23, 0, 1, 1, 4'd0, 8'd0, 1, "push_overflow");
        check("count_overflow", int'(count), 8);

        pop_id   = 4'd7;
        pop_prio = 8'd2;
        do_req(3, OP_POP, 4'd0, 8'd0, 1, 1, 0, 4'd7, 8'd2, 4, "pop_ok");
        check("count_pop", int'(count), 7);

        hit_cfg = 1'b1;
        do_req(0, OP_DROP, 4'd4, 8'd0, 1, 1, 0, 4'd0, 8'd0, 3, "drop_hit");
        check("count_drop_hit", int'(count), 6);
        hit_cfg = 1'b0;
        do_req(0, OP_DROP, 4'd9, 8'd0, 1, 1, 1, 4'd0, 8'd0, 3, "drop_miss");
        check("count_drop_miss", int'(count), 6);

        do_req(1, OP_PUSH, 4'd0, 8'd3, 0, 1, 1, 4'd0, 8'd0, 1, "push_id0");
        do_req(2, OP_BAD, 4'd5, 8'd3, 0, 1, 1, 4'd0, 8'd0, 1, "op_illegal");
        check("count_after_errs", int'(count), 6);

        // Stray pop strobe during a push wait must be ignored.
        stray    = 1'b1;
        push_lat = 3;
        do_req(3, OP_PUSH, 4'd10, 8'd1, 1, 1, 0, 4'd0, 8'd0, 5, "push_stray");
        check("count_stray", int'(count), 7);
        stray    = 1'b0;
        push_lat = 1;

        // Array never answers.
        withhold = 1'b1;
`ifdef PQ_ARB_TIMEOUT_EN
        do_req(0, OP_PUSH, 4'd11, 8'd3, 1, 1, 1, 4'd0, 8'd0, 18, "push_timeout");
        check("timeout_flag", int'(timeout), 1);
        check("count_timeout", int'(count), 7);
`else
        base = rsp_cnt;
        do_req(0, OP_PUSH, 4'd11, 8'd3, 1, 0, 0, 4'd0, 8'd0, 0, "push_stuck");
        repeat (40) @(negedge clk);
        #1;
        check("stuck_no_rsp", rsp_cnt - base, 0);
        check("stuck_timeout_flag", int'(timeout), 0);
        check("stuck_state", int'(dbg_state), 2);
        check("stuck_count", int'(count), 7);
        reset_dut();
`endif

        // Reset while waiting: command abandoned, no response.
        base = rsp_cnt;
        do_req(1, OP_PUSH, 4'd12, 8'd4, 1, 0, 0, 4'd0, 8'd0, 0, "push_hang");
        repeat (3) @(negedge clk);
        #1;
        check("hang_state", int'(dbg_state), 2);
        reset_dut();
        repeat (10) @(negedge clk);
        #1;
        check("hang_no_rsp", rsp_cnt - base, 0);
        check("hang_count", int'(count), 0);
        check("hang_state_idle", int'(dbg_state), 0);
        check("hang_timeout_clr", int'(timeout), 0);
        withhold = 1'b0;
        @(posedge clk); #1;

        do_req(2, OP_PUSH, 4'd2, 8'd9, 1, 1, 0, 4'd0, 8'd0, 3, "push_recover");
        check("count_recover", int'(count), 1);

        check("rsp_q_drained", exp_rsp_q.size(), 0);
        check("cmd_q_drained", exp_cmd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pq_cmd_arbiter.md
# pq_cmd_arbiter

Command arbiter and sequencer in front of the priority-queue cell array. Accepts push/pop/drop requests from `NR` requesters, grants one at a time in round-robin order, and issues it to the array head as a single-cycle command pulse. Waits for the array's completion strobe, then returns a response to the granted requester. Tracks queue occupancy so that over- and underflow are rejected before they reach the array.

## Interface
Parameters:
- `NR`, 4, number of requesters (≥2)
- `IW`, 4, entry ID width; ID 0 is reserved as "empty"
- `PW`, 8, priority width
- `DEPTH`, 8, number of cells in the array
- `TO_CYC`, 16, completion timeout in cycles (used only with `PQ_ARB_TIMEOUT_EN`)

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  synchronous reset, active-high
- `req_valid_i`  in  NR  request valid per requester
- `req_op_i`  in  2*NR  op per requester: 00 push, 01 pop, 10 drop, 11 illegal
- `req_id_i`  in  IW*NR  ID to push or drop
- `req_prio_i`  in  PW*NR  priority to push
- `req_ready_o`  out  NR  grant; one-hot or zero
- `rsp_valid_o`  out  NR  one-cycle response strobe to the granted requester
- `rsp_err_o`  out  1  response error flag, qualified by any `rsp_valid_o`
- `rsp_id_o`  out  IW  popped ID; 0 for push/drop
- `rsp_prio_o`  out  PW  popped priority; 0 for push/drop
- `pq_push_o`, `pq_pop_o`, `pq_drop_o`  out  1 each  one-cycle command pulses to the array
- `pq_id_o`  out  IW  push ID, or drop ID
- `pq_prio_o`  out  PW  push priority
- `pq_push_vld_i`, `pq_pop_vld_i`, `pq_drop_vld_i`  in  1 each  array completion strobes
- `pq_drop_hit_i`  in  1  qualifies `pq_drop_vld_i`: the ID was present and removed
- `pq_id_i`  in  IW  head ID, valid with `pq_pop_vld_i`
- `pq_prio_i`  in  PW  head priority, valid with `pq_pop_vld_i`
- `count_o`  out  $clog2(DEPTH+1)  current occupancy
- `timeout_o`  out  1  sticky timeout flag

## Operation
State machine states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - `req_ready_o[w]` is driven combinationally for the round-robin winner `w` among `req_valid_i`. The search starts at `rr_ptr`.
  - On the handshake, latch the op, ID, priority and `w`, and set `rr_ptr <= (w+1) mod NR`.
  - The latched request is checked:
    - illegal op → error
    - push with `count==DEPTH` → error
    - push with ID 0 → error
    - pop with `count==0` → error
  - Error → RESP with err=1; the array is not touched. Otherwise → ISSUE.
- **ISSUE**
  - Assert exactly one of `pq_push_o`/`pq_pop_o`/`pq_drop_o` for one cycle, with `pq_id_o`/`pq_prio_o` driven from the latches → WAIT.
- **WAIT**
  - Hold until the strobe matching the issued op arrives. Strobes for other ops are ignored.
  - Push vld: `count+1`.
  - Pop vld: capture `pq_id_i`/`pq_prio_i`, `count-1`.
  - Drop vld: `count-1` only if `pq_drop_hit_i`; err = ~`pq_drop_hit_i`.
  - On the strobe → RESP.
- **RESP**
  - `rsp_valid_o[w]=1` for one cycle, together with `rsp_err_o`/`rsp_id_o`/`rsp_prio_o` → IDLE.
  - No grant is issued in RESP.
- Arithmetic: `count` saturates at 0 and `DEPTH`. These limits are unreachable given the pre-checks.
- Pipe outputs (`pq_*_o`, `rsp_*_o`) are 0 whenever they are not asserted.

## Timing
- Reset values:
  - state IDLE, `rr_ptr=0`, `count_o=0`, `timeout_o=0`
  - all `pq_*_o`, `rsp_*_o` = 0
  - `req_ready_o` = 0 during reset
- A reset mid-operation abandons the command without a response. The array must be reset in the same cycle.
- Request accepted in cycle T; command pulse in T+1.
- The array answers push in ≥1 cycle and pop in ≥2 cycles after the pulse.
- Response is one cycle after the completion strobe. Minimum push turnaround: accept T, rsp T+3. Minimum pop turnaround: rsp T+4.
- Error path: accept T, rsp T+1.
- One command in flight at a time. The next grant is possible in the cycle after RESP.
- Requesters hold `req_*` stable until ready. Dropping valid before ready is allowed.

## Configuration
- `PQ_ARB_TIMEOUT_EN` defined:
  - WAIT runs a cycle counter. If it reaches `TO_CYC` without the matching strobe → RESP with err=1, `count` unchanged, `timeout_o` set.
  - `timeout_o` stays set until reset.
  - A strobe arriving late, after the timeout, is ignored.
- Undefined: WAIT holds indefinitely, no counter is synthesised, and `timeout_o` is tied 0.

## Test plan
- Reset, NR=4, requester 0 pushes ID 3/prio 5 → `pq_push_o` pulse one cycle after accept with `pq_id_o=3`, `pq_prio_o=5`; array vld 1 cycle later; `rsp_valid_o[0]` with err=0; `count_o=1`.
- All 4 requesters push IDs 1–4 continuously → grants in order 0,1,2,3,0; `count_o` reaches 4; a 9th push into a full DEPTH=8 array gets err=1 at accept+1 with no `pq_push_o`.
- Pop with `count_o=0` → err=1, no `pq_pop_o`. After pushes, pop with array returning ID 7/prio 2 → `rsp_id_o=7`, `rsp_prio_o=2`, count decrements.
- Drop ID 4 with `pq_drop_hit_i=1` → err=0, count−1. Drop ID 9 with hit=0 → err=1, count unchanged.
- Stray `pq_pop_vld_i` while waiting for a push is ignored. Op 11 → err=1. Reset asserted in WAIT → `count_o=0`, no `rsp_valid_o`.
- With `PQ_ARB_TIMEOUT_EN`, TO_CYC=16: withhold the strobe → err=1 response at 16 cycles in WAIT + 1, `timeout_o=1`, count unchanged. Without the macro, the same stimulus → no response and `timeout_o=0`.
